// File: rtl/fmc_test_pkg.sv
// Shared types and helpers for the FMC loopback checker: FSM states,
// error counter sizing and the pattern generator.
package fmc_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } fmc_state_e;

    localparam int                   ERR_CNT_W   = 16;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

    // Widest pin bus the pattern helper can describe; callers truncate to n bits.
    localparam int PAT_MAX_W = 1024;

    function automatic logic [PAT_MAX_W-1:0] pattern_word(input int step, input int n);
        logic [PAT_MAX_W-1:0] ones;
        logic [PAT_MAX_W-1:0] unit;
        ones = {PAT_MAX_W{1'b1}} >> (PAT_MAX_W - n);
        unit = {{(PAT_MAX_W-1){1'b0}}, 1'b1};
        if (step == 0)
            return '0;
        else if (step == 1)
            return ones;
        else if (step < n + 2)
            return unit << (step - 2);
        else
            return ones & ~(unit << (step - n - 2));
    endfunction

endpackage

// File: rtl/fmc_pin_sync.sv
// Multi-stage synchroniser for the asynchronous returning FMC pins.
module fmc_pin_sync #(
    parameter int N_PINS      = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [N_PINS-1:0] d_in,
    output logic [N_PINS-1:0] d_out
);

    logic [SYNC_STAGES-1:0][N_PINS-1:0] sync_q;
    logic [SYNC_STAGES-1:0][N_PINS-1:0] sync_d;

    always_comb begin
        sync_d[0] = d_in;
        for (int i = 1; i < SYNC_STAGES; i++)
            sync_d[i] = sync_q[i-1];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= sync_d;
    end

    assign d_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/fmc_loopback_checker.sv
// Drives walking/solid patterns onto the FMC loopback TX pins and compares
// the synchronised RX return, accumulating per-pin and per-step failures.
module fmc_loopback_checker
    import fmc_test_pkg::*;
#(
    parameter int N_PINS        = 64,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic [N_PINS-1:0]                rx_pins,
    output logic [N_PINS-1:0]                tx_pins,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic [N_PINS-1:0]                fail_mask,
    output logic [ERR_CNT_W-1:0]             err_count,
    output logic [$clog2(2*N_PINS+2)-1:0]    step_idx
);

    localparam int STEPS = 2*N_PINS + 2;
    localparam int SW    = $clog2(STEPS);
    localparam int CW    = $clog2(SETTLE_CYCLES);

    localparam logic [SW-1:0] LAST_IDX      = SW'(STEPS - 1);
    localparam logic [CW-1:0] SETTLE_RELOAD = CW'(SETTLE_CYCLES - 1);

    fmc_state_e           state_q, state_d;
    logic [SW-1:0]        step_q, step_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [N_PINS-1:0]    tx_q, tx_d;
    logic [N_PINS-1:0]    mask_q, mask_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;

    logic [N_PINS-1:0]    rx_sync;
    logic [N_PINS-1:0]    diff;
    logic [N_PINS-1:0]    mask_upd;
    logic [SW-1:0]        pat_step;
    logic [N_PINS-1:0]    pat_word;

    fmc_pin_sync #(
        .N_PINS      (N_PINS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d_in    (rx_pins),
        .d_out   (rx_sync)
    );

    assign diff     = rx_sync ^ tx_q;
    assign mask_upd = mask_q | diff;

    // The only pattern ever loaded is step 0 on start or the following step after a check.
    always_comb begin
        pat_step = (state_q == ST_CHECK) ? step_q + 1'b1 : '0;
        pat_word = N_PINS'(pattern_word(int'(pat_step), N_PINS));
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        tx_d        = tx_q;
        mask_d      = mask_q;
        err_count_d = err_count_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    step_d      = '0;
                    tx_d        = pat_word;
                    cnt_d       = SETTLE_RELOAD;
                    mask_d      = '0;
                    err_count_d = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) state_d = ST_CHECK;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_CHECK: begin
                mask_d = mask_upd;
                if (diff != '0 && err_count_q != ERR_CNT_MAX)
                    err_count_d = err_count_q + 1'b1;
                if (step_q == LAST_IDX) begin
                    tx_d    = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (mask_upd == '0);
                    state_d = ST_DONE;
                end else begin
                    step_d  = step_q + 1'b1;
                    tx_d    = pat_word;
                    cnt_d   = SETTLE_RELOAD;
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            cnt_q       <= '0;
            tx_q        <= '0;
            mask_q      <= '0;
            err_count_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            mask_q      <= mask_d;
            err_count_q <= err_count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign tx_pins   = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = mask_q;
    assign err_count = err_count_q;
    assign step_idx  = step_q;

endmodule

// File: doc/fmc_loopback_checker.md
Name: fmc_loopback_checker

Overview:
- Receive-side counterpart of the FMC pin driver. Drives a deterministic pattern sequence onto the FMC loopback TX pins, samples the returning RX pins through synchronisers, and compares them against the driven word.
- Reports which pins fail and how many pattern steps mismatched.
- Sits at top level between the FMC connector I/O and the board status/debug registers.

Parameters:
- N_PINS, 64, number of looped-back pins (tx and rx bus width), must be >= 2
- SYNC_STAGES, 2, flip-flop stages on each rx pin, must be >= 2
- SETTLE_CYCLES, 16, cycles each pattern is held before compare, must be >= SYNC_STAGES+1

Ports:
- clock  input  1  single system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a run when idle or done
- rx_pins  input  N_PINS  returning FMC pins, asynchronous to clock
- tx_pins  output  N_PINS  registered pattern driven to FMC pins
- busy  output  1  high while a run is in progress
- done  output  1  high from run completion until next accepted start
- pass  output  1  valid when done; 1 iff fail_mask == 0
- fail_mask  output  N_PINS  sticky per-pin mismatch flags for the current run
- err_count  output  16  number of steps with any mismatch; saturates at 16'hFFFF
- step_idx  output  $clog2(2*N_PINS+2)  current pattern step, for debug

Behaviour:
- Interface: one clock, `clock`; reset `reset_n` is asynchronous, active-low.
- Reset values: tx_pins=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0, step_idx=0, all sync flops=0, state=IDLE.
- Pattern sequence. There are 2*N_PINS+2 steps; LAST = 2*N_PINS+1.
  - step 0: all zeros
  - step 1: all ones
  - steps 2..N_PINS+1: walking one, bit (step-2) set
  - steps N_PINS+2..LAST: walking zero, bit (step-N_PINS-2) clear
- rx_sync: rx_pins passed through SYNC_STAGES flops. There is no other rx filtering.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE with start=1 (transition on the same edge):
  - step_idx<=0, tx_pins<=pattern(0), settle_cnt<=SETTLE_CYCLES-1
  - fail_mask<=0, err_count<=0, done<=0, pass<=0, busy<=1
  - next state SETTLE
- SETTLE: settle_cnt decrements each cycle; when settle_cnt==0 go to CHECK. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- CHECK (exactly one cycle):
  - diff = rx_sync ^ tx_pins; fail_mask <= fail_mask | diff.
  - If diff != 0, err_count increments unless already 16'hFFFF.
  - If step_idx==LAST: tx_pins<=0, busy<=0, done<=1, pass<=(final fail_mask==0), next state DONE. The final mask includes this step's diff.
  - Otherwise: step_idx++, tx_pins<=pattern(step_idx+1), reload settle_cnt, next state SETTLE.
- Timing: each step takes SETTLE_CYCLES+1 cycles. done rises (SETTLE_CYCLES+1)*(2*N_PINS+2) rising edges after the edge that accepted start.
- start while busy is ignored, with no effect on the run.
- start in DONE clears the previous results and restarts the run.
- reset_n low at any time, including mid-run, returns everything to reset values immediately (asynchronously).
- Results fail_mask, err_count, pass and done hold stable in DONE until the next accepted start.

Decomposition:
- Package fmc_test_pkg holds:
  - state enum typedef (IDLE, SETTLE, CHECK, DONE)
  - ERR_CNT_W=16 and ERR_CNT_MAX constant
  - function pattern_word(step, n) returning the step's pattern
- Sub-module fmc_pin_sync: parameterised SYNC_STAGES-deep, N_PINS-wide synchroniser, reset by reset_n to 0.

Test Plan (N_PINS=8, SYNC_STAGES=2, SETTLE_CYCLES=4 unless stated):
- rx_pins tied to tx_pins, pulse start -> busy for 90 cycles, done=1 after edge 90, pass=1, fail_mask=8'h00, err_count=0.
- rx_pins[3] stuck at 0, other bits looped -> fail_mask=8'h08, err_count=9, pass=0.
- rx bits 0 and 1 swapped -> fail_mask=8'h03, err_count=4, pass=0.
- start pulsed at cycles 10 and 40 of a run -> both pulses ignored; done still at edge 90. A second start in DONE clears fail_mask/err_count and the run repeats with identical timing.
- reset_n asserted at cycle 37 mid-run -> all outputs return to reset values in the same cycle. After release plus a start, a full passing run completes in 90 cycles.
- Saturation, forced err_count preload of 16'hFFFE via a bench hook, all rx inverted -> err_count stops at 16'hFFFF, fail_mask=8'hFF.
